// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci engine.
package fib_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NW    = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/fib_if.sv
// Control/result bundle between the switch logic and the Fibonacci engine.
interface fib_if
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NW    = DEF_NW
);

    logic             start;
    logic             abort;
    logic             mode;
    logic [NW-1:0]    n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             valid;
    logic [WIDTH-1:0] term;

    modport master (
        output start, abort, mode, n,
        input  busy, done, result, overflow, valid, term
    );

    modport slave (
        input  start, abort, mode, n,
        output busy, done, result, overflow, valid, term
    );

endinterface

// File: rtl/fib_engine.sv
// Fibonacci engine: one term per clock, final or streamed output,
// sticky overflow tracking and abort.
module fib_engine
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NW    = DEF_NW
) (
    input logic clk,
    input logic reset,
    fib_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ova;
    logic             ovb;
    logic [NW-1:0]    cnt;
    logic             mode_q;
    logic [WIDTH-1:0] res_q;
    logic             ovf_q;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            ova    <= 1'b0;
            ovb    <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a      <= '0;
                        b      <= WIDTH'(1);
                        ova    <= 1'b0;
                        ovb    <= 1'b0;
                        cnt    <= bus.n;
                        mode_q <= bus.mode;
                        state  <= (bus.n == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        a   <= b;
                        b   <= sum[WIDTH-1:0];
                        ova <= ovb;
                        // ovb carries the overflow of F(k+1), never reported
                        ovb <= ova | ovb | sum[WIDTH];
                        cnt <= cnt - 1'b1;
                        if (cnt == NW'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!bus.abort) begin
                        res_q <= a;
                        ovf_q <= ova;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // abort in DONE suppresses the pulse along with the update
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE) && !bus.abort;
    assign bus.valid    = mode_q && (state != IDLE);
    assign bus.term     = a;
    assign bus.result   = res_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_fib_engine.sv
// Scoreboard bench for fib_engine: random and directed runs
// checked against an arithmetic Fibonacci model.
module tb_fib_engine;

    import fib_pkg::*;

    localparam int W  = 16;
    localparam int NW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fib_if #(.WIDTH(W), .NW(NW)) bus ();

    fib_engine #(.WIDTH(W), .NW(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint         cyc;
        logic [W-1:0]   res;
        bit             ov;
    } exp_t;

    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;
    exp_t    done_q[$];
    logic [W-1:0] term_q[$];
    bit      ignore_stream = 1'b0;
    bit      pend = 1'b0;
    exp_t    pe;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endfunction

    // Exact value mod 2^W plus a saturating true value for overflow.
    function automatic void model(int unsigned k,
                                  output logic [W-1:0] r,
                                  output bit ov);
        longint x = 0, y = 1, t;
        longint lim = longint'(1) << 40;
        int unsigned xm = 0, ym = 1, tm;
        for (int unsigned i = 0; i < k; i++) begin
            t  = x + y;
            x  = y;
            y  = (t > lim) ? lim : t;
            tm = (xm + ym) % (1 << W);
            xm = ym;
            ym = tm;
        end
        r  = W'(xm);
        ov = (x >= (longint'(1) << W));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int nn, bit m, bit push);
        exp_t e;
        logic [W-1:0] r;
        bit o;
        bus.start = 1'b1;
        bus.n     = NW'(nn);
        bus.mode  = m;
        if (push) begin
            model(nn, e.res, e.ov);
            e.cyc = cyc + nn + 1;
            done_q.push_back(e);
            if (m) begin
                for (int k = 0; k <= nn; k++) begin
                    model(k, r, o);
                    term_q.push_back(r);
                end
            end
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (bus.busy && i < 600) begin
            tick();
            i++;
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_overflow"}, bus.overflow, 0);
        check({tag, "_term"}, bus.term, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                check("result", bus.result, pe.res);
                check("overflow", bus.overflow, pe.ov);
                pend = 1'b0;
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual 1 required 0");
                end else begin
                    pe = done_q.pop_front();
                    check("done_cycle", cyc, pe.cyc);
                    pend = 1'b1;
                end
            end
            if (bus.valid && !ignore_stream) begin
                if (term_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual 1 required 0");
                end else begin
                    check("term", bus.term, term_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = 1'b0;
        bus.n     = '0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        issue(2, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("busy_window", bus.busy, (i <= 3) ? 1 : 0);
            tick();
        end

        issue(7, 1'b1, 1'b1);
        wait_idle();
        issue(0, 1'b0, 1'b1);
        wait_idle();
        issue(1, 1'b0, 1'b1);
        wait_idle();
        issue(24, 1'b0, 1'b1);
        wait_idle();
        issue(25, 1'b1, 1'b1);
        wait_idle();

        issue(10, 1'b0, 1'b1);
        repeat (3) tick();
        bus.start = 1'b1;
        bus.n     = NW'(3);
        tick();
        bus.start = 1'b0;
        wait_idle();
        tick();
        check("ignored_start", bus.result, 55);

        issue(20, 1'b0, 1'b0);
        repeat (2) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        repeat (3) tick();
        check("abort_result", bus.result, 55);

        issue(3, 1'b0, 1'b0);
        repeat (3) tick();
        bus.abort = 1'b1;
        #1;
        check("abort_done_gate", bus.done, 0);
        tick();
        bus.abort = 1'b0;
        tick();
        check("abort_done_busy", bus.busy, 0);
        check("abort_done_result", bus.result, 55);

        bus.abort = 1'b1;
        issue(6, 1'b0, 1'b1);
        bus.abort = 1'b0;
        wait_idle();

        ignore_stream = 1'b1;
        issue(15, 1'b1, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_zero("midrun_reset");
        reset = 1'b0;
        ignore_stream = 1'b0;
        tick();
        issue(5, 1'b0, 1'b1);
        wait_idle();

        repeat (25) begin
            int nn;
            bit m;
            nn = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 40));
            m  = 1'($urandom_range(0, 1));
            issue(nn, m, 1'b1);
            wait_idle();
        end

        repeat (3) tick();
        check("done_queue_empty", done_q.size(), 0);
        check("term_queue_empty", term_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
